// File: rtl/ctrl_resolve_if.sv
// Signal bundle between the control execute pipe, the CTI-queue update port and fetch recovery.
// master = environment side, slave = ctrl_resolve_stage side.
interface ctrl_resolve_if #(
    parameter int AL_W  = 7,
    parameter int CTI_W = 5,
    parameter int PC_W  = 32
);
    logic              flush;
    logic              wb_valid;
    logic              wb_mispred;
    logic [AL_W-1:0]   wb_al_id;
    logic [CTI_W-1:0]  wb_cti_id;
    logic              wb_dir;
    logic [PC_W-1:0]   wb_next_pc;
    logic              wb_ic_flush;
    logic [AL_W-1:0]   al_head;
    logic              stall;
    logic              cti_upd_valid;
    logic              cti_upd_ready;
    logic [CTI_W-1:0]  cti_upd_id;
    logic              cti_upd_dir;
    logic [PC_W-1:0]   cti_upd_tgt;
    logic              rec_req;
    logic              rec_ack;
    logic [AL_W-1:0]   rec_al_id;
    logic [PC_W-1:0]   rec_pc;
    logic              ic_flush_req;
    logic              rec_busy;

    modport master (
        output flush, wb_valid, wb_mispred, wb_al_id, wb_cti_id, wb_dir, wb_next_pc,
               wb_ic_flush, al_head, cti_upd_ready, rec_ack,
        input  stall, cti_upd_valid, cti_upd_id, cti_upd_dir, cti_upd_tgt,
               rec_req, rec_al_id, rec_pc, ic_flush_req, rec_busy
    );

    modport slave (
        input  flush, wb_valid, wb_mispred, wb_al_id, wb_cti_id, wb_dir, wb_next_pc,
               wb_ic_flush, al_head, cti_upd_ready, rec_ack,
        output stall, cti_upd_valid, cti_upd_id, cti_upd_dir, cti_upd_tgt,
               rec_req, rec_al_id, rec_pc, ic_flush_req, rec_busy
    );
endinterface

// File: rtl/ctrl_resolve_stage.sv
// Control writeback/resolve stage: wbPkt register, CTI-queue update FIFO and mispredict-recovery FSM.
// Optional CTRL_RESOLVE_PERF_EN adds saturating recovery / stall-cycle counters.
module ctrl_resolve_stage #(
    parameter int UPD_DEPTH = 4,
    parameter int AL_W      = 7,
    parameter int CTI_W     = 5,
    parameter int PC_W      = 32,
    parameter int DRAIN_CYC = 3
) (
    input  logic clk,
    input  logic reset,
    ctrl_resolve_if.slave bus
`ifdef CTRL_RESOLVE_PERF_EN
    ,
    output logic [31:0] perf_mispred,
    output logic [31:0] perf_upd_stall
`endif
);
    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DC_W  = $clog2(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] STALL_LVL  = CNT_W'(UPD_DEPTH - 1);
    localparam logic [DC_W-1:0]  DRAIN_LOAD = DC_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;

    logic              st_valid_r;
    logic              st_mispred_r;
    logic [AL_W-1:0]   st_al_id_r;
    logic [CTI_W-1:0]  st_cti_id_r;
    logic              st_dir_r;
    logic [PC_W-1:0]   st_pc_r;
    logic              st_ic_flush_r;

    logic [CTI_W-1:0]  mem_id_r  [UPD_DEPTH];
    logic              mem_dir_r [UPD_DEPTH];
    logic [PC_W-1:0]   mem_tgt_r [UPD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;

    state_t            state_r;
    logic              rec_req_r;
    logic              rec_busy_r;
    logic [AL_W-1:0]   rec_al_id_r;
    logic [PC_W-1:0]   rec_pc_r;
    logic [DC_W-1:0]   drain_cnt_r;
    logic              ic_flush_r;

    logic push_s;
    logic pop_s;
    logic stall_s;
    logic mis_s;
    logic older_s;

    // Distance from the active-list head; wraps across ID 0 so smaller always means older.
    function automatic logic [AL_W-1:0] age(input logic [AL_W-1:0] id, input logic [AL_W-1:0] head);
        return id - head;
    endfunction

    assign push_s  = st_valid_r;
    assign pop_s   = (cnt_r != {CNT_W{1'b0}}) && bus.cti_upd_ready;
    assign stall_s = (cnt_r >= STALL_LVL);
    assign mis_s   = st_valid_r && st_mispred_r && !bus.flush;
    assign older_s = (age(st_al_id_r, bus.al_head) < age(rec_al_id_r, bus.al_head));

    // wbPkt capture; a squash drops whatever is being captured on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid_r    <= 1'b0;
            st_mispred_r  <= 1'b0;
            st_al_id_r    <= {AL_W{1'b0}};
            st_cti_id_r   <= {CTI_W{1'b0}};
            st_dir_r      <= 1'b0;
            st_pc_r       <= {PC_W{1'b0}};
            st_ic_flush_r <= 1'b0;
        end else begin
            st_valid_r    <= bus.wb_valid && !bus.flush;
            st_mispred_r  <= bus.wb_mispred;
            st_al_id_r    <= bus.wb_al_id;
            st_cti_id_r   <= bus.wb_cti_id;
            st_dir_r      <= bus.wb_dir;
            st_pc_r       <= bus.wb_next_pc;
            st_ic_flush_r <= bus.wb_ic_flush;
        end
    end

    // CTIQ update FIFO; the stall threshold leaves room for the one entry already in the stage reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_id_r[i]  <= {CTI_W{1'b0}};
                mem_dir_r[i] <= 1'b0;
                mem_tgt_r[i] <= {PC_W{1'b0}};
            end
        end else if (bus.flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_id_r[wr_ptr_r]  <= st_cti_id_r;
                mem_dir_r[wr_ptr_r] <= st_dir_r;
                mem_tgt_r[wr_ptr_r] <= st_pc_r;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Recovery FSM: oldest mispredict wins while waiting for ack, then a fixed drain window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            rec_req_r   <= 1'b0;
            rec_busy_r  <= 1'b0;
            rec_al_id_r <= {AL_W{1'b0}};
            rec_pc_r    <= {PC_W{1'b0}};
            drain_cnt_r <= {DC_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (mis_s) begin
                        state_r     <= REQ;
                        rec_req_r   <= 1'b1;
                        rec_busy_r  <= 1'b1;
                        rec_al_id_r <= st_al_id_r;
                        rec_pc_r    <= st_pc_r;
                    end
                end
                REQ: begin
                    if (bus.flush) begin
                        state_r    <= IDLE;
                        rec_req_r  <= 1'b0;
                        rec_busy_r <= 1'b0;
                    end else if (mis_s && older_s) begin
                        rec_al_id_r <= st_al_id_r;
                        rec_pc_r    <= st_pc_r;
                    end else if (bus.rec_ack) begin
                        state_r     <= DRAIN;
                        rec_req_r   <= 1'b0;
                        drain_cnt_r <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == {DC_W{1'b0}}) begin
                        state_r    <= IDLE;
                        rec_busy_r <= 1'b0;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DC_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    rec_req_r  <= 1'b0;
                    rec_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // FENCE.I flush request, one cycle behind the stage entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            ic_flush_r <= 1'b0;
        end else begin
            ic_flush_r <= st_valid_r && st_ic_flush_r && !bus.flush;
        end
    end

`ifdef CTRL_RESOLVE_PERF_EN
    logic [31:0] perf_mispred_r;
    logic [31:0] perf_upd_stall_r;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_mispred_r   <= 32'd0;
            perf_upd_stall_r <= 32'd0;
        end else begin
            if ((state_r == REQ) && bus.rec_ack && (perf_mispred_r != 32'hFFFF_FFFF)) begin
                perf_mispred_r <= perf_mispred_r + 32'd1;
            end
            if (stall_s && (perf_upd_stall_r != 32'hFFFF_FFFF)) begin
                perf_upd_stall_r <= perf_upd_stall_r + 32'd1;
            end
        end
    end

    assign perf_mispred   = perf_mispred_r;
    assign perf_upd_stall = perf_upd_stall_r;
`endif

    assign bus.stall         = stall_s;
    assign bus.cti_upd_valid = (cnt_r != {CNT_W{1'b0}});
    assign bus.cti_upd_id    = mem_id_r[rd_ptr_r];
    assign bus.cti_upd_dir   = mem_dir_r[rd_ptr_r];
    assign bus.cti_upd_tgt   = mem_tgt_r[rd_ptr_r];
    assign bus.rec_req       = rec_req_r;
    assign bus.rec_busy      = rec_busy_r;
    assign bus.rec_al_id     = rec_al_id_r;
    assign bus.rec_pc        = rec_pc_r;
    assign bus.ic_flush_req  = ic_flush_r;
endmodule
